ram_stream_reader: RTL and testbench

//   Read-side initiator for the single-port synchronous-read block RAM.

---
 rtl/ram_stream_reader_pkg.sv | 18 +
 rtl/ram_stream_reader_fifo2.sv | 47 ++++
 rtl/ram_stream_reader.sv | 110 +++++++++++
 tb/tb_ram_stream_reader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared types for the RAM stream reader: controller states and the
// read-slot occupancy helper used by the issue rule.
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic [2:0] occupancy(input logic [1:0] count,
                                             input logic       inflight,
                                             input logic       pop);
        return 3'(count) + 3'(inflight) - 3'(pop);
    endfunction

endpackage

// File: rtl/ram_stream_reader_fifo2.sv
// Two-entry register FIFO; the head comes straight from storage registers so
// the stream outputs never depend combinationally on the consumer's ready.
module ram_stream_reader_fifo2 #(
    parameter int WIDTH = 33
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == 2'd0);

endmodule

// File: rtl/ram_stream_reader.sv
// Sequential block-RAM reader: issues raddr for base..base+length-1, absorbs
// the RAM's one-cycle read latency and streams words out over valid/ready.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    state_t                state;
    state_t                state_next;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  inflight;
    logic                  inflight_last;
    logic [1:0]            fifo_count;
    logic                  fifo_empty;
    logic [DATA_WIDTH:0]   fifo_head;
    logic                  pop;
    logic                  issue;
    logic                  last_issue;

    assign pop        = m_valid && m_ready;
    assign issue      = (state == ST_RUN) && (remaining != '0) &&
                        (occupancy(fifo_count, inflight, pop) < 3'd2);
    assign last_issue = issue && (remaining == LEN_WIDTH'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero-length transfer still passes through RUN so that busy is seen
    // for one cycle and done lands two cycles after start.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN: begin
                if (remaining == '0) begin
                    state_next = ST_DONE;
                end else if (last_issue) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: if (pop && m_last) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN) || (state == ST_DRAIN);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            raddr         <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                raddr     <= base_addr;
                remaining <= length;
            end else if (issue) begin
                raddr     <= raddr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            inflight      <= issue;
            inflight_last <= last_issue;
        end
    end

    ram_stream_reader_fifo2 #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight),
        .push_data ({inflight_last, rdata}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_head[DATA_WIDTH-1:0];
    assign m_last  = fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomised self-checking bench for ram_stream_reader against a RAM with
// mem[i]=i and a queue model of the expected beat sequence.
module tb_ram_stream_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic [12:0] length = '0;
    logic        busy;
    logic        done;
    logic [11:0] raddr;
    logic [31:0] rdata = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_last;

    int errors = 0;
    int checks = 0;

    ram_stream_reader #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(32),
        .LEN_WIDTH (13)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .raddr     (raddr),
        .rdata     (rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    always #5 clock = ~clock;

    // Synchronous-read RAM whose contents equal the address.
    always @(posedge clock) rdata <= 32'(raddr);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic ready_at(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 5) >= 3;
        return $urandom_range(0, 3) != 0;
    endfunction

    // mode: 0 ready always high, 1 three-low/two-high, 2 random.
    task automatic run(input logic [11:0] b, input int n, input int mode,
                       input int abort_after, input int spurious_at);
        logic [31:0] exp_q[$];
        logic        exp_last_q[$];
        int          beats = 0;
        int          last_hs = -1;
        int          budget = 4 * n + 40;
        logic        finished = 1'b0;
        logic        aborted = 1'b0;
        logic        stalled = 1'b0;
        logic [31:0] held_d = '0;
        logic        held_l = 1'b0;

        for (int i = 0; i < n; i++) begin
            exp_q.push_back((32'(b) + 32'(i)) & 32'hFFF);
            exp_last_q.push_back(i == n - 1);
        end

        base_addr = b;
        length    = 13'(n);
        start     = 1'b1;
        m_ready   = ready_at(mode, 0);
        step();
        start = 1'b0;

        for (int c = 1; c <= budget; c++) begin
            m_ready = ready_at(mode, c);
            if (spurious_at > 0 && c == spurious_at) begin
                start     = 1'b1;
                base_addr = b ^ 12'h555;
                length    = 13'd3;
            end else begin
                start = 1'b0;
            end

            if (c == 1) check_eq("busy_t1", 32'(busy), 32'd1);
            if (mode == 0 && c <= n)
                check_eq("raddr_seq", 32'(raddr), (32'(b) + 32'(c - 1)) & 32'hFFF);

            if (stalled) begin
                check_eq("stall_valid", 32'(m_valid), 32'd1);
                check_eq("stall_data", m_data, held_d);
                check_eq("stall_last", 32'(m_last), 32'(held_l));
            end

            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("beat_overrun", 32'(beats + 1), 32'(n));
                end else begin
                    check_eq("beat_data", m_data, exp_q.pop_front());
                    check_eq("beat_last", 32'(m_last), 32'(exp_last_q.pop_front()));
                    if (mode == 0) check_eq("beat_cycle", 32'(c), 32'(3 + beats));
                end
                beats++;
                if (m_last) last_hs = c;
            end

            stalled = m_valid && !m_ready;
            held_d  = m_data;
            held_l  = m_last;

            if (done) begin
                check_eq("done_cycle", 32'(c), (n == 0) ? 32'd2 : 32'(last_hs + 1));
                check_eq("busy_at_done", 32'(busy), 32'd0);
                finished = 1'b1;
                break;
            end

            if (abort_after > 0 && beats == abort_after) begin
                aborted = 1'b1;
                break;
            end

            step();
        end
        start = 1'b0;

        check_eq("completed", 32'(finished | aborted), 32'd1);

        if (aborted) begin
            step();
            reset = 1'b1;
            step();
            reset = 1'b0;
            check_eq("abort_valid", 32'(m_valid), 32'd0);
            check_eq("abort_busy", 32'(busy), 32'd0);
            check_eq("abort_done", 32'(done), 32'd0);
            for (int k = 0; k < 6; k++) begin
                step();
                check_eq("abort_quiet", 32'({done, m_valid, busy}), 32'd0);
            end
        end else begin
            check_eq("beat_total", 32'(beats), 32'(n));
            step();
            check_eq("done_pulse_end", 32'(done), 32'd0);
            check_eq("idle_busy", 32'(busy), 32'd0);
            check_eq("idle_valid", 32'(m_valid), 32'd0);
        end
        m_ready = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) step();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_valid", 32'(m_valid), 32'd0);
        check_eq("rst_last", 32'(m_last), 32'd0);
        check_eq("rst_data", m_data, 32'd0);
        check_eq("rst_raddr", 32'(raddr), 32'd0);
        reset = 1'b0;
        step();

        run(12'h010, 4, 0, 0, 0);
        run(12'h000, 0, 0, 0, 0);
        run(12'h000, 16, 1, 0, 0);
        run(12'hFFE, 4, 0, 0, 0);
        run(12'h100, 8, 0, 2, 0);
        run(12'h020, 2, 0, 0, 0);
        run(12'h040, 6, 0, 0, 2);

        for (int t = 0; t < 10; t++) begin
            run(12'($urandom_range(0, 4095)), int'($urandom_range(0, 12)), 2, 0, 0);
        end
        run(12'hFFA, 12, 2, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
